// File: rtl/cg_ctrl.sv
// cg_ctrl: idle-detect clock-gating controller with sleep handshake and gated-cycle statistics
module cg_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy_i,
  input  logic              wake_req_i,
  input  logic              sleep_ack_i,
  input  logic              stat_clr_i,
  output logic              cg_en,
  output logic              sleep_req,
  output logic              awake,
  output logic [STAT_W-1:0] gated_cycles
);
  typedef enum logic [1:0] {RUN, REQ, GATED, WAKE} state_t;
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);
  localparam logic [7:0]  WAKE_LAST = 8'(WAKE_CYCLES - 1);
  state_t      state, state_nx;
  logic [15:0] idle_cnt, idle_nx;
  logic [7:0]  wake_cnt, wake_nx;
  logic        wake;
  assign wake = busy_i | wake_req_i;
  always_comb begin
    state_nx = state;
    idle_nx  = idle_cnt;
    wake_nx  = wake_cnt;
    case (state)
      RUN: begin
        idle_nx  = wake ? 16'd0 : (idle_cnt == IDLE_LAST) ? 16'd0 : idle_cnt + 16'd1;
        state_nx = (!wake && idle_cnt == IDLE_LAST) ? REQ : RUN;
      end
      REQ: begin
        state_nx = wake ? RUN : sleep_ack_i ? GATED : REQ;
        idle_nx  = 16'd0;
      end
      GATED: begin
        state_nx = wake ? WAKE : GATED;
        wake_nx  = 8'd0;
      end
      WAKE: begin
        // a lingering ack holds us here even after the wake delay has elapsed
        state_nx = (wake_cnt == WAKE_LAST && !sleep_ack_i) ? RUN : WAKE;
        wake_nx  = (wake_cnt == WAKE_LAST) ? wake_cnt : wake_cnt + 8'd1;
        idle_nx  = 16'd0;
      end
      default: state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      idle_cnt     <= '0;
      wake_cnt     <= '0;
      cg_en        <= 1'b1;
      sleep_req    <= 1'b0;
      awake        <= 1'b1;
      gated_cycles <= '0;
    end else begin
      state        <= state_nx;
      idle_cnt     <= idle_nx;
      wake_cnt     <= wake_nx;
      cg_en        <= state_nx != GATED;
      sleep_req    <= state_nx == REQ || state_nx == GATED;
      awake        <= state_nx == RUN || state_nx == REQ;
      gated_cycles <= stat_clr_i ? '0 :
                      (state == GATED && !(&gated_cycles)) ? gated_cycles + STAT_W'(1) : gated_cycles;
    end
  end
endmodule

// File: tb/tb_cg_ctrl.sv
// tb_cg_ctrl: directed and randomized checks of cg_ctrl against a behavioural model
module tb_cg_ctrl;
  localparam int IDLE = 4, WAKE = 2, SW = 4;
  logic clk = 0, rst = 1, busy_i = 0, wake_req_i = 0, sleep_ack_i = 0, stat_clr_i = 0;
  logic cg_en, sleep_req, awake;
  logic [SW-1:0] gated_cycles;
  logic [6:0] obs;
  int vec = 0, miss = 0;
  int m_mode = 0, m_idle = 0, m_age = 0, m_gated = 0;
  cg_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .busy_i(busy_i), .wake_req_i(wake_req_i), .sleep_ack_i(sleep_ack_i),
    .stat_clr_i(stat_clr_i), .cg_en(cg_en), .sleep_req(sleep_req), .awake(awake),
    .gated_cycles(gated_cycles)
  );
  always #5 clk = ~clk;
  assign obs = {cg_en, sleep_req, awake, gated_cycles};
  // mode: 0 running, 1 asking to sleep, 2 gated, 3 waking
  function automatic logic [6:0] exp_out();
    return {m_mode != 2, m_mode == 1 || m_mode == 2, m_mode < 2, SW'(m_gated)};
  endfunction
  task automatic model_step();
    bit w;
    w = busy_i || wake_req_i;
    if (rst) begin
      m_mode = 0; m_idle = 0; m_gated = 0;
      return;
    end
    m_gated = stat_clr_i ? 0 : (m_mode == 2 && m_gated < (1 << SW) - 1) ? m_gated + 1 : m_gated;
    case (m_mode)
      0: begin
        m_idle = w ? 0 : m_idle + 1;
        if (m_idle == IDLE) begin m_mode = 1; m_idle = 0; end
      end
      1: m_mode = w ? 0 : sleep_ack_i ? 2 : 1;
      2: if (w) begin m_mode = 3; m_age = 0; end
      default: begin
        m_age++;
        if (m_age >= WAKE && !sleep_ack_i) begin m_mode = 0; m_idle = 0; end
      end
    endcase
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask
  task automatic recover();
    sleep_ack_i = 0; wake_req_i = 1; stat_clr_i = 0;
    tick();
    wake_req_i = 0; busy_i = 1;
    tick(4);
  endtask
  task automatic test_reset();
    rst = 1; busy_i = 0; wake_req_i = 0; sleep_ack_i = 0; stat_clr_i = 0;
    tick(2);
    vec++;
    if (obs !== 7'b1010000) begin miss++; $display("FAIL reset: got %b exp %b", obs, 7'b1010000); end
    rst = 0;
    tick();
    vec++;
    if (obs !== exp_out()) begin miss++; $display("FAIL reset_release: got %b exp %b", obs, exp_out()); end
  endtask
  task automatic test_idle_entry();
    busy_i = 1; sleep_ack_i = 1;
    tick(2);
    vec++;
    if (obs !== exp_out() || sleep_req !== 1'b0) begin miss++; $display("FAIL busy_hold: got %b exp %b", obs, exp_out()); end
    busy_i = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vec++;
      if (obs !== exp_out() || sleep_req !== (i >= 4) || cg_en !== (i < 5) || awake !== (i < 5))
        begin miss++; $display("FAIL idle_entry step %0d: got %b exp %b", i, obs, exp_out()); end
    end
    recover();
  endtask
  task automatic test_restart();
    busy_i = 0; sleep_ack_i = 0;
    tick(2);
    busy_i = 1;
    tick();
    busy_i = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      vec++;
      if (obs !== exp_out() || sleep_req !== (i == 4))
        begin miss++; $display("FAIL restart step %0d: got %b exp %b", i, obs, exp_out()); end
    end
    tick(20);
    vec++;
    if (obs !== exp_out() || sleep_req !== 1'b1 || cg_en !== 1'b1)
      begin miss++; $display("FAIL req_no_timeout: got %b exp %b", obs, exp_out()); end
  endtask
  task automatic test_req_wake_priority();
    sleep_ack_i = 1; wake_req_i = 1;
    tick();
    vec++;
    if (obs !== exp_out() || sleep_req !== 1'b0 || cg_en !== 1'b1 || awake !== 1'b1)
      begin miss++; $display("FAIL req_wake_prio: got %b exp %b", obs, exp_out()); end
    recover();
  endtask
  task automatic test_wake_exit(int hold);
    busy_i = 0; sleep_ack_i = 1;
    tick(IDLE + 4);
    wake_req_i = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      vec++;
      if (obs !== exp_out() || cg_en !== 1'b1 || awake !== (k >= ((hold + 1 > 3) ? hold + 1 : 3)) ||
          (k == 1 && sleep_req !== 1'b0))
        begin miss++; $display("FAIL wake_exit hold %0d step %0d: got %b exp %b", hold, k, obs, exp_out()); end
      wake_req_i = 0;
      sleep_ack_i = k < hold;
    end
    recover();
  endtask
  task automatic test_saturation();
    busy_i = 0; sleep_ack_i = 1;
    tick(IDLE + 1);
    tick(100);
    vec++;
    if (obs !== exp_out() || gated_cycles !== 4'd15)
      begin miss++; $display("FAIL saturate: got %0d exp 15", gated_cycles); end
    stat_clr_i = 1;
    tick();
    stat_clr_i = 0;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (obs !== exp_out() || gated_cycles !== SW'(i) || cg_en !== 1'b0)
        begin miss++; $display("FAIL stat_clr step %0d: got %0d exp %0d", i, gated_cycles, i); end
      tick();
    end
  endtask
  task automatic test_async_reset();
    vec++;
    if (cg_en !== 1'b0 || awake !== 1'b0) begin miss++; $display("FAIL pre_reset_gated: got %b exp gated", obs); end
    rst = 1;
    #1;
    m_mode = 0; m_idle = 0; m_gated = 0;
    vec++;
    if (obs !== 7'b1010000) begin miss++; $display("FAIL async_reset: got %b exp %b", obs, 7'b1010000); end
    tick();
    rst = 0; sleep_ack_i = 0; busy_i = 1;
    tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      busy_i      = $urandom_range(0, 9) == 0;
      wake_req_i  = $urandom_range(0, 14) == 0;
      sleep_ack_i = $urandom_range(0, 3) != 0;
      stat_clr_i  = $urandom_range(0, 39) == 0;
      tick();
      vec++;
      if (obs !== exp_out()) begin miss++; $display("FAIL random cycle %0d: got %b exp %b", i, obs, exp_out()); end
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_idle_entry();
    test_restart();
    test_req_wake_priority();
    test_wake_exit(1);
    test_wake_exit(6);
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
